// File: rtl/gpio_init_ctrl.sv
// Power-on sequencer for one gpio_regs block: writes DATA, CONTROL, then OEN, and then passes the port bus to the CPU.
// Define GPIO_INIT_VERIFY_EN to add CONTROL/OEN readback checks that drive a sticky init_error.
module gpio_init_ctrl #(
    parameter logic [7:0] GPIO_BASE_ADDRESS = 8'h00,
    parameter logic [7:0] INIT_DATA         = 8'h00,
    parameter logic [7:0] INIT_CONTROL      = 8'h00,
    parameter logic [7:0] INIT_OEN          = 8'h00,
    parameter logic [7:0] START_DELAY       = 8'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cpu_port_id,
    input  logic [7:0] cpu_out_port,
    input  logic       cpu_write_strobe,
    input  logic       cpu_read_strobe,
    output logic [7:0] cpu_in_port,
    output logic       cpu_sleep,
    output logic [7:0] per_port_id,
    output logic [7:0] per_data_in,
    output logic       per_write_strobe,
    output logic       per_read_strobe,
    input  logic [7:0] per_data_out,
    output logic       init_done,
    output logic       init_error
);

    localparam logic [3:0] ST_DELAY    = 4'd0;
    localparam logic [3:0] ST_WR_DATA  = 4'd1;
    localparam logic [3:0] ST_WR_CTRL  = 4'd2;
    localparam logic [3:0] ST_WR_OEN   = 4'd5;
    localparam logic [3:0] ST_DONE     = 4'd8;
`ifdef GPIO_INIT_VERIFY_EN
    localparam logic [3:0] ST_RD_CTRL  = 4'd3;
    localparam logic [3:0] ST_CHK_CTRL = 4'd4;
    localparam logic [3:0] ST_RD_OEN   = 4'd6;
    localparam logic [3:0] ST_CHK_OEN  = 4'd7;
`endif

    localparam logic [7:0] ADDR_OEN  = GPIO_BASE_ADDRESS;
    localparam logic [7:0] ADDR_DATA = GPIO_BASE_ADDRESS + 8'd1;
    localparam logic [7:0] ADDR_CTRL = GPIO_BASE_ADDRESS + 8'd2;

    logic [3:0] state_r;
    logic [3:0] state_s;
    logic [7:0] delay_cnt_r;
    logic       armed_r;
    logic       init_done_r;
    logic       cpu_sleep_r;

    // Start-up delay counter; the first edge after reset only arms it, so DELAY spans START_DELAY full cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_r     <= 1'b0;
            delay_cnt_r <= START_DELAY;
        end else if (state_r == ST_DELAY && armed_r && delay_cnt_r > 8'd1) begin
            armed_r     <= 1'b1;
            delay_cnt_r <= delay_cnt_r - 8'd1;
        end else begin
            armed_r     <= 1'b1;
            delay_cnt_r <= delay_cnt_r;
        end
    end

    // Next-state logic of the init sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_DELAY: begin
                if (armed_r && delay_cnt_r <= 8'd1) begin
                    state_s = ST_WR_DATA;
                end else begin
                    state_s = ST_DELAY;
                end
            end
            ST_WR_DATA:  state_s = ST_WR_CTRL;
`ifdef GPIO_INIT_VERIFY_EN
            ST_WR_CTRL:  state_s = ST_RD_CTRL;
            ST_RD_CTRL:  state_s = ST_CHK_CTRL;
            ST_CHK_CTRL: state_s = ST_WR_OEN;
            ST_WR_OEN:   state_s = ST_RD_OEN;
            ST_RD_OEN:   state_s = ST_CHK_OEN;
            ST_CHK_OEN:  state_s = ST_DONE;
`else
            ST_WR_CTRL:  state_s = ST_WR_OEN;
            ST_WR_OEN:   state_s = ST_DONE;
`endif
            ST_DONE:     state_s = ST_DONE;
            default:     state_s = ST_DELAY;
        endcase
    end

    // State register plus registered handover flags, which track entry into DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_DELAY;
            init_done_r <= 1'b0;
            cpu_sleep_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            init_done_r <= (state_s == ST_DONE);
            cpu_sleep_r <= (state_s != ST_DONE);
        end
    end

    // Port-bus ownership: sequencer drives from state and constants; the CPU is connected only in DONE
    always_comb begin
        per_port_id      = 8'h00;
        per_data_in      = 8'h00;
        per_write_strobe = 1'b0;
        per_read_strobe  = 1'b0;
        case (state_r)
            ST_WR_DATA: begin
                per_port_id      = ADDR_DATA;
                per_data_in      = INIT_DATA;
                per_write_strobe = 1'b1;
            end
            ST_WR_CTRL: begin
                per_port_id      = ADDR_CTRL;
                per_data_in      = INIT_CONTROL;
                per_write_strobe = 1'b1;
            end
            ST_WR_OEN: begin
                per_port_id      = ADDR_OEN;
                per_data_in      = INIT_OEN;
                per_write_strobe = 1'b1;
            end
`ifdef GPIO_INIT_VERIFY_EN
            ST_RD_CTRL: begin
                per_port_id     = ADDR_CTRL;
                per_read_strobe = 1'b1;
            end
            ST_RD_OEN: begin
                per_port_id     = ADDR_OEN;
                per_read_strobe = 1'b1;
            end
`endif
            ST_DONE: begin
                per_port_id      = cpu_port_id;
                per_data_in      = cpu_out_port;
                per_write_strobe = cpu_write_strobe;
                per_read_strobe  = cpu_read_strobe;
            end
            default: begin
                per_port_id      = 8'h00;
                per_data_in      = 8'h00;
                per_write_strobe = 1'b0;
                per_read_strobe  = 1'b0;
            end
        endcase
    end

`ifdef GPIO_INIT_VERIFY_EN
    logic init_error_r;
    logic chk_fail_s;

    // Readback compare; the peripheral registered data_out on the preceding RD edge
    always_comb begin
        chk_fail_s = 1'b0;
        case (state_r)
            ST_CHK_CTRL: chk_fail_s = (per_data_out != INIT_CONTROL);
            ST_CHK_OEN:  chk_fail_s = (per_data_out != INIT_OEN);
            default:     chk_fail_s = 1'b0;
        endcase
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_error_r <= 1'b0;
        end else begin
            init_error_r <= init_error_r | chk_fail_s;
        end
    end

    assign init_error = init_error_r;
`else
    assign init_error = 1'b0;
`endif

    assign cpu_in_port = per_data_out;
    assign cpu_sleep   = cpu_sleep_r;
    assign init_done   = init_done_r;

endmodule

// File: tb/tb_gpio_init_ctrl.sv
// Self-checking bench for gpio_init_ctrl with a small gpio_regs model; sequencer bus traffic is scoreboarded.
`timescale 1ns/1ps
module tb_gpio_init_ctrl;

    localparam logic [7:0] BASE   = 8'h10;
    localparam logic [7:0] I_DATA = 8'hA5;
    localparam logic [7:0] I_CTRL = 8'h3C;
    localparam logic [7:0] I_OEN  = 8'hF0;
    localparam logic [7:0] SD     = 8'd4;
    localparam int         SDI    = 4;
    localparam logic [7:0] PINS   = 8'h5A;
`ifdef GPIO_INIT_VERIFY_EN
    localparam int HANDOVER = SDI + 7;
`else
    localparam int HANDOVER = SDI + 3;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cpu_port_id = 8'h00;
    logic [7:0] cpu_out_port = 8'h00;
    logic       cpu_write_strobe = 1'b0;
    logic       cpu_read_strobe = 1'b0;
    logic [7:0] cpu_in_port;
    logic       cpu_sleep;
    logic [7:0] per_port_id;
    logic [7:0] per_data_in;
    logic       per_write_strobe;
    logic       per_read_strobe;
    logic [7:0] per_data_out;
    logic       init_done;
    logic       init_error;

    int n_checks = 0;
    int n_fail = 0;
    int cyc;

    gpio_init_ctrl #(
        .GPIO_BASE_ADDRESS(BASE),
        .INIT_DATA(I_DATA),
        .INIT_CONTROL(I_CTRL),
        .INIT_OEN(I_OEN),
        .START_DELAY(SD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_port_id(cpu_port_id),
        .cpu_out_port(cpu_out_port),
        .cpu_write_strobe(cpu_write_strobe),
        .cpu_read_strobe(cpu_read_strobe),
        .cpu_in_port(cpu_in_port),
        .cpu_sleep(cpu_sleep),
        .per_port_id(per_port_id),
        .per_data_in(per_data_in),
        .per_write_strobe(per_write_strobe),
        .per_read_strobe(per_read_strobe),
        .per_data_out(per_data_out),
        .init_done(init_done),
        .init_error(init_error)
    );

    always #5 clk = ~clk;

    // Cycle number: 0 is the first rising edge with reset low
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= -1;
        else       cyc <= cyc + 1;
    end

    // gpio_regs model: OEN at +0, DATA at +1 (reads return pins), CONTROL at +2
    logic [7:0] g_oen, g_data, g_ctrl, g_dout;
    logic       force_ctrl_zero = 1'b0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            g_oen <= 8'h00; g_data <= 8'h00; g_ctrl <= 8'h00; g_dout <= 8'h00;
        end else begin
            if (per_write_strobe) begin
                if (per_port_id == BASE)              g_oen  <= per_data_in;
                else if (per_port_id == BASE + 8'd1)  g_data <= per_data_in;
                else if (per_port_id == BASE + 8'd2)  g_ctrl <= per_data_in;
            end
            if (per_read_strobe) begin
                if (per_port_id == BASE)              g_dout <= g_oen;
                else if (per_port_id == BASE + 8'd2)  g_dout <= force_ctrl_zero ? 8'h00 : g_ctrl;
                else                                  g_dout <= PINS;
            end
        end
    end
    assign per_data_out = g_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected sequencer bus operations
    typedef struct {
        int         cyc;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_op_t;
    bus_op_t exp_q[$];
    bus_op_t op;

    task automatic push_sequence();
        exp_q.push_back('{SDI,     1'b1, BASE + 8'd1, I_DATA});
        exp_q.push_back('{SDI + 1, 1'b1, BASE + 8'd2, I_CTRL});
`ifdef GPIO_INIT_VERIFY_EN
        exp_q.push_back('{SDI + 2, 1'b0, BASE + 8'd2, 8'h00});
        exp_q.push_back('{SDI + 4, 1'b1, BASE,        I_OEN});
        exp_q.push_back('{SDI + 5, 1'b0, BASE,        8'h00});
`else
        exp_q.push_back('{SDI + 2, 1'b1, BASE,        I_OEN});
`endif
    endtask

    // Monitor: every strobe while the sequencer owns the bus must match the scoreboard head
    always @(negedge clk) begin
        if (!reset && cpu_sleep && (per_write_strobe || per_read_strobe)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got port %0h wr %0b rd %0b at cycle %0d, expected none",
                         per_port_id, per_write_strobe, per_read_strobe, cyc);
            end else begin
                op = exp_q.pop_front();
                check("strobe_cycle", cyc, op.cyc);
                check("strobe_is_write", {31'd0, per_write_strobe}, {31'd0, op.wr});
                check("strobe_is_read", {31'd0, per_read_strobe}, {31'd0, ~op.wr});
                check("strobe_addr", {24'd0, per_port_id}, {24'd0, op.addr});
                if (op.wr) check("strobe_data", {24'd0, per_data_in}, {24'd0, op.data});
            end
        end
    end

    task automatic check_idle_bus(input string tag);
        check({tag, "_port_id"}, {24'd0, per_port_id}, 32'd0);
        check({tag, "_data_in"}, {24'd0, per_data_in}, 32'd0);
        check({tag, "_strobes"}, {30'd0, per_write_strobe, per_read_strobe}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_idle_bus(tag);
        check({tag, "_sleep"}, {31'd0, cpu_sleep}, 32'd1);
        check({tag, "_done"}, {31'd0, init_done}, 32'd0);
        check({tag, "_error"}, {31'd0, init_error}, 32'd0);
    endtask

    task automatic start_run();
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("reset");
        exp_q.delete();
        push_sequence();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int k;
        k = 0;
        while (cyc < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("wait_cycle_reached", cyc, n);
    endtask

    task automatic wait_done(input logic exp_err);
        int k;
        k = 0;
        while (init_done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("done_cycle", cyc, HANDOVER);
        check("sleep_after_done", {31'd0, cpu_sleep}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
        check("error_at_done", {31'd0, init_error}, {31'd0, exp_err});
        @(negedge clk);
        check("gpio_oen", {24'd0, g_oen}, {24'd0, I_OEN});
        check("gpio_data", {24'd0, g_data}, {24'd0, I_DATA});
        check("gpio_ctrl", {24'd0, g_ctrl}, {24'd0, I_CTRL});
    endtask

    // Pass-through vectors: CPU inputs, expected per_* outputs, expected cpu_in_port after the edge
    typedef struct {
        logic [7:0] port;
        logic [7:0] data;
        logic       ws;
        logic       rs;
        logic [7:0] e_id;
        logic [7:0] e_din;
        logic       e_ws;
        logic       e_rs;
        logic       chk_in;
        logic [7:0] e_in;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h10, 8'h0F, 1'b1, 1'b0, 8'h10, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{8'h10, 8'hC3, 1'b0, 1'b1, 8'h10, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h0F};
        vecs[2] = '{8'h55, 8'hAA, 1'b0, 1'b0, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h0F};
        vecs[3] = '{8'h12, 8'h81, 1'b1, 1'b0, 8'h12, 8'h81, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{8'h12, 8'h00, 1'b0, 1'b1, 8'h12, 8'h00, 1'b0, 1'b1, 1'b1, 8'h81};

        // Run 1: default sequence, with a CPU write attempted during DELAY
        start_run();
        wait_cyc(1);
        check_idle_bus("delay");
        wait_cyc(2);
        cpu_port_id = BASE;
        cpu_out_port = 8'h77;
        cpu_write_strobe = 1'b1;
        #1;
        check("cpu_strobe_blocked", {31'd0, per_write_strobe}, 32'd0);
        check("cpu_port_blocked", {24'd0, per_port_id}, 32'd0);
        @(negedge clk);
        cpu_write_strobe = 1'b0;
        check("oen_untouched", {24'd0, g_oen}, 32'd0);
        wait_done(1'b0);

        // Pass-through after handover
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cpu_port_id = vecs[i].port;
            cpu_out_port = vecs[i].data;
            cpu_write_strobe = vecs[i].ws;
            cpu_read_strobe = vecs[i].rs;
            #1;
            check("pt_port_id", {24'd0, per_port_id}, {24'd0, vecs[i].e_id});
            check("pt_data_in", {24'd0, per_data_in}, {24'd0, vecs[i].e_din});
            check("pt_write_strobe", {31'd0, per_write_strobe}, {31'd0, vecs[i].e_ws});
            check("pt_read_strobe", {31'd0, per_read_strobe}, {31'd0, vecs[i].e_rs});
            @(posedge clk);
            #1;
            if (vecs[i].chk_in) check("pt_cpu_in_port", {24'd0, cpu_in_port}, {24'd0, vecs[i].e_in});
        end
        @(negedge clk);
        cpu_write_strobe = 1'b0;
        cpu_read_strobe = 1'b0;
        check("still_done", {31'd0, init_done}, 32'd1);

        // Run 2: reset asserted during WR_CTRL, then a full repeat
        start_run();
        wait_cyc(SDI + 1);
        check("in_wr_ctrl", {31'd0, per_write_strobe}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midreset");
        exp_q.delete();
        push_sequence();
        @(negedge clk);
        reset = 1'b0;
        wait_done(1'b0);

`ifdef GPIO_INIT_VERIFY_EN
        // Run 3: CONTROL readback forced to zero
        force_ctrl_zero = 1'b1;
        start_run();
        wait_cyc(SDI + 2);
        check("error_before_chk", {31'd0, init_error}, 32'd0);
        wait_cyc(SDI + 3);
        check("error_in_chk_ctrl", {31'd0, init_error}, 32'd0);
        @(negedge clk);
        check("error_after_chk_ctrl", {31'd0, init_error}, 32'd1);
        wait_done(1'b1);
        repeat (3) @(negedge clk);
        check("error_sticky", {31'd0, init_error}, 32'd1);
        reset = 1'b1;
        #1;
        check("error_cleared_by_reset", {31'd0, init_error}, 32'd0);
        force_ctrl_zero = 1'b0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpio_init_ctrl.md
# gpio_init_ctrl

Power-on configuration sequencer and port-bus owner for one `gpio_regs` instance on the Picoblaze I/O bus. After reset it holds the CPU in sleep and drives the port bus itself, writing parameterised DATA, CONTROL and OEN values into the GPIO block. It then hands the bus to the CPU as a pass-through. `init_done` marks the handover.

## Interface
Parameters:
- `GPIO_BASE_ADDRESS`, 8'h00: base port address of the target GPIO block. OEN is at +0, DATA at +1, CONTROL at +2.
- `INIT_DATA`, 8'h00: value written to DATA.
- `INIT_CONTROL`, 8'h00: value written to CONTROL.
- `INIT_OEN`, 8'h00: value written to OEN.
- `START_DELAY`, 8'd4: cycles spent in DELAY before the first write. Legal range is 1–255.

Ports:
- `clk` in 1: single clock. All logic uses its rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `cpu_port_id` in 8: CPU port address.
- `cpu_out_port` in 8: CPU write data.
- `cpu_write_strobe` in 1: CPU write strobe.
- `cpu_read_strobe` in 1: CPU read strobe.
- `cpu_in_port` out 8: CPU read data.
- `cpu_sleep` out 1: high while the sequencer owns the bus.
- `per_port_id` out 8: to the peripheral `port_id`.
- `per_data_in` out 8: to the peripheral `data_in`.
- `per_write_strobe` out 1: to the peripheral write strobe.
- `per_read_strobe` out 1: to the peripheral read strobe.
- `per_data_out` in 8: from the peripheral `data_out`.
- `init_done` out 1: high once the sequence is complete.
- `init_error` out 1: sticky readback-mismatch flag. Constant 0 without `GPIO_INIT_VERIFY_EN`.

## Operation
- **FSM states:** DELAY → WR_DATA → WR_CTRL → WR_OEN → DONE. With verify, the states are DELAY → WR_DATA → WR_CTRL → RD_CTRL → CHK_CTRL → WR_OEN → RD_OEN → CHK_OEN → DONE.
- **Write order:** DATA and CONTROL are written before OEN, so pins never drive a stale value.
- **DELAY:**
  - An 8-bit down-counter is loaded with `START_DELAY` at reset.
  - The FSM leaves DELAY on the cycle the counter reaches 1.
- **WR_x states:** each lasts exactly one cycle, with `per_write_strobe`=1, `per_port_id`=base+offset and `per_data_in`=INIT value.
- **RD_x states:** one cycle with `per_read_strobe`=1 and `per_port_id`=target address.
- **CHK_x states:**
  - Compare `per_data_out` against the expected INIT value.
  - On mismatch, set `init_error`.
  - The sequence always continues.
  - DATA is never verified, because reads at +1 return pin input, not the written value.
- **Bus outputs during sequencing:** all `per_*` outputs are decoded from registered state and constants only, with no path from `cpu_*`. In DELAY and CHK states, the strobes are 0 and address and data are 0.
- **CPU strobes before DONE:** dropped and not queued. `cpu_in_port` = `per_data_out` at all times.
- **DONE:** terminal until reset.
  - `per_port_id`=`cpu_port_id`, `per_data_in`=`cpu_out_port` and the strobes equal the CPU strobes, all combinationally.
  - `cpu_sleep`=0 and `init_done`=1.
- **Reset values, asserted asynchronously:** state=DELAY, `cpu_sleep`=1, `init_done`=0, `init_error`=0, all `per_*` outputs 0.
- **Reset mid-sequence:** abort immediately and restart from DELAY with the full delay. Partially written GPIO registers are rewritten.

## Timing
- Cycle 0 is the first rising edge with `reset` low.
- **Without verify:**
  - WR_DATA occupies cycle `START_DELAY`, WR_CTRL `START_DELAY`+1 and WR_OEN `START_DELAY`+2.
  - `init_done` and `cpu_sleep` change at the edge ending cycle `START_DELAY`+2, i.e. `START_DELAY`+3 cycles after cycle 0.
- **With verify:**
  - Each RD strobe is followed by CHK one cycle later; the peripheral registers `data_out` on the RD edge.
  - Handover occurs `START_DELAY`+7 cycles after cycle 0.
- **Strobes:** every sequencer strobe is a single-cycle pulse. Address and data are stable for the whole strobe cycle.
- **Handover:** no pass-through or sequencer strobe is lost or duplicated at the handover edge.

## Configuration
- **`GPIO_INIT_VERIFY_EN` defined:** the RD/CHK states are present and `init_error` is live.
- **Not defined:**
  - RD/CHK states and the compare logic are compiled out.
  - `init_error` is tied to 0.
  - The sequence is 3 write cycles.

## Test plan
- **Default sequence:** `START_DELAY`=4, INIT_DATA=8'hA5, INIT_CONTROL=8'h3C, INIT_OEN=8'hF0, base 8'h10.
  - Writes are (11,A5) at cycle 4, (12,3C) at cycle 5 and (10,F0) at cycle 6.
  - `init_done`=1 and `cpu_sleep`=0 from cycle 7.
- **CPU strobe during init:** `cpu_write_strobe` pulsed at cycle 2 → no `per_write_strobe` at cycle 2; the GPIO register is unchanged.
- **Pass-through:** after DONE, CPU write (port 10, data 0F) → `per_*` mirrors the CPU in the same cycle; the GPIO OEN reads 0F.
- **Mid-sequence reset:** reset asserted during WR_CTRL → all outputs are 0 and `cpu_sleep`=1 immediately. After release, the full sequence repeats from cycle 0.
- **Verify pass:** `GPIO_INIT_VERIFY_EN` defined with a correct peripheral → `init_done` at cycle `START_DELAY`+7 and `init_error`=0.
- **Verify fail:** `GPIO_INIT_VERIFY_EN` defined with the peripheral CONTROL readback forced to 8'h00 → `init_error`=1 from CHK_CTRL onwards, the sequence still completes, and `init_error` clears only on reset.
